vfd_scan_capture: RTL and testbench

- Sits between the ucom43 CPU port outputs and the vfd renderer.
- Samples the multiplexed VFD grid strobes and segment lines and rejects transition glitches and ghost strobes.
- Holds one segment row per grid with a per-grid persistence timer, emulating phosphor afterglow so rows do not flicker.
- The renderer reads rows through a registered read port and redraws only when the changed pulse fires.

---
 rtl/vfd_scan_capture_if.sv | 23 ++
 rtl/vfd_scan_capture.sv | 111 +++++++++++
 tb/tb_vfd_scan_capture.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vfd_scan_capture_if.sv
// vfd_scan_capture_if: CPU-port capture side and renderer read side of the VFD scan capture block
interface vfd_scan_capture_if #(
  parameter int GRIDS = 10,
  parameter int SEGS  = 20,
  parameter int GW    = $clog2(GRIDS)
);
  logic             ce;
  logic [GRIDS-1:0] grid_in;
  logic [SEGS-1:0]  seg_in;
  logic [GW-1:0]    rd_grid;
  logic [SEGS-1:0]  rd_segs;
  logic             changed;
  logic [GRIDS-1:0] active_grids;
  logic [7:0]       ghost_cnt;
  modport master (
    output ce, grid_in, seg_in, rd_grid,
    input  rd_segs, changed, active_grids, ghost_cnt
  );
  modport slave (
    input  ce, grid_in, seg_in, rd_grid,
    output rd_segs, changed, active_grids, ghost_cnt
  );
endinterface

// File: rtl/vfd_scan_capture.sv
// vfd_scan_capture: deglitches multiplexed VFD strobes and holds per-grid rows with afterglow timers
module vfd_scan_capture #(
  parameter int GRIDS     = 10,
  parameter int SEGS      = 20,
  parameter int STABLE    = 4,
  parameter int PERSIST   = 3000,
  parameter int PERSIST_W = 12,
  parameter int GW        = $clog2(GRIDS)
) (
  input logic               clk,
  input logic               reset_n,
  vfd_scan_capture_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] QUAL = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [3:0] STB  = 4'(STABLE);
  logic [1:0]           state_q, state_d;
  logic [GW-1:0]        cand_grid_q, cand_grid_d, idx;
  logic [SEGS-1:0]      cand_seg_q, cand_seg_d, rd_segs_q, rd_segs_d;
  logic [3:0]           qcnt_q, qcnt_d;
  logic [7:0]           ghost_cnt_q, ghost_cnt_d;
  logic                 changed_q, changed_d;
  logic [SEGS-1:0]      row_q [GRIDS];
  logic [SEGS-1:0]      row_d [GRIDS];
  logic [PERSIST_W-1:0] cnt_q [GRIDS];
  logic [PERSIST_W-1:0] cnt_d [GRIDS];
  logic                 blank, ghost, same, commit;
  always_comb begin
    idx = '0;
    for (int g = 0; g < GRIDS; g++) if (bus.grid_in[g]) idx = GW'(g);
  end
  assign blank = bus.grid_in == '0;
  assign ghost = (bus.grid_in & (bus.grid_in - GRIDS'(1))) != '0;
  assign same  = idx == cand_grid_q && bus.seg_in == cand_seg_q;
  always_comb begin
    state_d     = state_q;
    cand_grid_d = cand_grid_q;
    cand_seg_d  = cand_seg_q;
    qcnt_d      = qcnt_q;
    ghost_cnt_d = ghost_cnt_q;
    commit      = 1'b0;
    if (bus.ce) begin
      if (ghost) begin
        state_d     = IDLE;
        ghost_cnt_d = ghost_cnt_q == 8'hff ? ghost_cnt_q : ghost_cnt_q + 8'd1;
      end else if (blank) begin
        state_d = IDLE;
      end else if (state_q != IDLE && same) begin
        qcnt_d  = qcnt_q >= STB ? qcnt_q : qcnt_q + 4'd1;
        commit  = state_q == HOLD || qcnt_q + 4'd1 >= STB;
        state_d = commit ? HOLD : QUAL;
      end else begin
        cand_grid_d = idx;
        cand_seg_d  = bus.seg_in;
        qcnt_d      = 4'd1;
        commit      = STB == 4'd1;
        state_d     = commit ? HOLD : QUAL;
      end
    end
  end
  // a committed grid reloads its timer; every other lit grid decays and blanks on expiry
  always_comb begin
    changed_d = 1'b0;
    for (int g = 0; g < GRIDS; g++) begin
      row_d[g] = row_q[g];
      cnt_d[g] = cnt_q[g];
      if (commit && idx == GW'(g)) begin
        row_d[g]  = bus.seg_in;
        cnt_d[g]  = PERSIST_W'(PERSIST);
        changed_d = changed_d | row_q[g] != bus.seg_in | cnt_q[g] == '0;
      end else if (bus.ce && cnt_q[g] != '0) begin
        cnt_d[g] = cnt_q[g] - PERSIST_W'(1);
        if (cnt_q[g] == PERSIST_W'(1)) begin
          row_d[g]  = '0;
          changed_d = 1'b1;
        end
      end
    end
  end
  assign rd_segs_d = int'(bus.rd_grid) < GRIDS ? row_q[bus.rd_grid] : '0;
  always_comb for (int g = 0; g < GRIDS; g++) bus.active_grids[g] = cnt_q[g] != '0;
  assign bus.rd_segs   = rd_segs_q;
  assign bus.changed   = changed_q;
  assign bus.ghost_cnt = ghost_cnt_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cand_grid_q <= '0;
      cand_seg_q  <= '0;
      qcnt_q      <= '0;
      ghost_cnt_q <= '0;
      changed_q   <= 1'b0;
      rd_segs_q   <= '0;
      for (int g = 0; g < GRIDS; g++) begin
        row_q[g] <= '0;
        cnt_q[g] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cand_grid_q <= cand_grid_d;
      cand_seg_q  <= cand_seg_d;
      qcnt_q      <= qcnt_d;
      ghost_cnt_q <= ghost_cnt_d;
      changed_q   <= changed_d;
      rd_segs_q   <= rd_segs_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_vfd_scan_capture.sv
// tb_vfd_scan_capture: directed and random stimulus against a run-length reference model
module tb_vfd_scan_capture;
  localparam int GRIDS = 10, SEGS = 20, STABLE = 4, PERSIST = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] rd_sel = '0;
  int n_checks = 0, n_fail = 0;
  vfd_scan_capture_if #(.GRIDS(GRIDS), .SEGS(SEGS)) bus ();
  vfd_scan_capture #(.GRIDS(GRIDS), .SEGS(SEGS), .STABLE(STABLE), .PERSIST(PERSIST), .PERSIST_W(12)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  logic [SEGS-1:0] m_row [GRIDS];
  int m_cnt [GRIDS];
  int m_ghost, run_len, run_g;
  logic [SEGS-1:0] run_s, exp_rd;
  logic exp_chg;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [GRIDS-1:0] m_active();
    logic [GRIDS-1:0] a;
    for (int g = 0; g < GRIDS; g++) a[g] = m_cnt[g] != 0;
    return a;
  endfunction
  // a grid commits once it has been seen alone with the same segments for STABLE consecutive ce samples
  task automatic model_tick(input bit c, input logic [GRIDS-1:0] gr, input logic [SEGS-1:0] sg);
    int cg, ones, g1;
    if (!reset_n) begin
      for (int g = 0; g < GRIDS; g++) begin m_row[g] = '0; m_cnt[g] = 0; end
      m_ghost = 0; run_len = 0; exp_rd = '0; exp_chg = 1'b0;
      return;
    end
    exp_rd = rd_sel < GRIDS ? m_row[rd_sel] : '0;
    exp_chg = 1'b0;
    if (!c) return;
    ones = $countones(gr);
    cg = -1;
    if (ones == 1) begin
      g1 = $clog2(gr);
      if (run_len > 0 && g1 == run_g && sg == run_s) run_len++;
      else begin run_g = g1; run_s = sg; run_len = 1; end
      if (run_len >= STABLE) cg = g1;
    end else begin
      run_len = 0;
      if (ones > 1 && m_ghost < 255) m_ghost++;
    end
    for (int g = 0; g < GRIDS; g++) begin
      if (g == cg) begin
        if (m_row[g] != sg || m_cnt[g] == 0) exp_chg = 1'b1;
        m_row[g] = sg; m_cnt[g] = PERSIST;
      end else if (m_cnt[g] > 0) begin
        m_cnt[g]--;
        if (m_cnt[g] == 0) begin m_row[g] = '0; exp_chg = 1'b1; end
      end
    end
  endtask
  task automatic step(input bit c, input logic [GRIDS-1:0] gr, input logic [SEGS-1:0] sg);
    bus.ce = c; bus.grid_in = gr; bus.seg_in = sg; bus.rd_grid = rd_sel;
    @(posedge clk);
    model_tick(c, gr, sg);
    #1;
    check("rd_segs", 32'(bus.rd_segs), 32'(exp_rd));
    check("changed", 32'(bus.changed), 32'(exp_chg));
    check("active_grids", 32'(bus.active_grids), 32'(m_active()));
    check("ghost_cnt", 32'(bus.ghost_cnt), 32'(m_ghost));
  endtask
  task automatic hold(input int n, input logic [GRIDS-1:0] gr, input logic [SEGS-1:0] sg);
    for (int i = 0; i < n; i++) step(1'b1, gr, sg);
  endtask
  initial begin
    logic [GRIDS-1:0] gr;
    logic [SEGS-1:0] sg;
    int len, a, b;
    reset_n = 1'b0;
    step(1'b1, 10'h000, '0);
    step(1'b1, 10'h3ff, 20'hfffff);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin rd_sel = 4'(i % GRIDS); step(1'b1, 10'h000, '0); end
    rd_sel = 4'd2;
    hold(3, 10'h004, 20'h0ABCD);
    check("qual_no_commit", 32'(bus.active_grids), 32'h0);
    hold(1, 10'h004, 20'h0ABCD);
    check("qual_active", 32'(bus.active_grids), 32'h004);
    step(1'b0, 10'h000, '0);
    check("qual_row", 32'(bus.rd_segs), 32'h0ABCD);
    hold(12, 10'h000, '0);
    rd_sel = 4'd3;
    hold(2, 10'h004, 20'h11111);
    hold(4, 10'h008, 20'h22222);
    hold(2, 10'h010, 20'h33333);
    hold(4, 10'h010, 20'h44444);
    hold(10, 10'h000, '0);
    hold(300, 10'h003, 20'h55555);
    check("ghost_sat", 32'(bus.ghost_cnt), 32'd255);
    reset_n = 1'b0; step(1'b1, 10'h000, '0); reset_n = 1'b1;
    rd_sel = 4'd5;
    hold(4, 10'h020, 20'h00001);
    hold(8, 10'h000, '0);
    check("persist_expired", 32'(bus.active_grids), 32'h0);
    hold(4, 10'h020, 20'h00001);
    hold(3, 10'h000, '0);
    hold(4, 10'h020, 20'h00001);
    hold(10, 10'h000, '0);
    rd_sel = 4'd1;
    hold(4, 10'h002, 20'h000FF);
    hold(1, 10'h000, '0);
    hold(4, 10'h002, 20'h00F00);
    check("rmw_old", 32'(bus.rd_segs), 32'h000FF);
    step(1'b0, 10'h000, '0);
    check("rmw_new", 32'(bus.rd_segs), 32'h00F00);
    hold(10, 10'h000, '0);
    hold(3, 10'h040, 20'h0F0F0);
    reset_n = 1'b0; step(1'b1, 10'h040, 20'h0F0F0); reset_n = 1'b1;
    hold(5, 10'h000, '0);
    check("reset_discard", 32'(bus.active_grids), 32'h0);
    rd_sel = 4'd12;
    hold(4, 10'h200, 20'h12345);
    step(1'b0, 10'h000, '0);
    for (int k = 0; k < 500; k++) begin
      a = $urandom_range(0, 9);
      if (a == 0) gr = '0;
      else if (a == 1) begin
        a = $urandom_range(0, GRIDS - 1);
        b = (a + $urandom_range(1, GRIDS - 1)) % GRIDS;
        gr = '0; gr[a] = 1'b1; gr[b] = 1'b1;
      end else begin
        gr = '0; gr[$urandom_range(0, 3) * 3] = 1'b1;
      end
      a = $urandom_range(0, 3);
      sg = a == 0 ? 20'h000FF : a == 1 ? 20'h00F00 : a == 2 ? 20'h00000 : SEGS'($urandom);
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        rd_sel = 4'($urandom_range(0, 15));
        reset_n = $urandom_range(0, 199) != 0;
        step($urandom_range(0, 3) != 0, gr, sg);
        reset_n = 1'b1;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
